r_register: RTL and testbench



---
 rtl/r_register.sv | 110 +++++++++++
 tb/tb_r_register.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/r_register.sv
// Router datapath register: latches the header, stages payload bytes onto dout,
// parks the byte that meets a full FIFO, and tracks packet parity and error status.
module r_register (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       parity_done,
  output logic       low_packet_valid,
  output logic       err
);

  logic [7:0] dout_d, dout_q;
  logic [7:0] header_reg_d, header_reg_q;
  logic [7:0] hold_reg_d, hold_reg_q;
  logic [7:0] int_parity_d, int_parity_q;
  logic [7:0] pkt_parity_d, pkt_parity_q;
  logic       parity_done_d, parity_done_q;
  logic       low_pkt_valid_d, low_pkt_valid_q;
  logic       err_d, err_q;
  logic       header_ok;
  logic       unused_full_state;

  // Nothing accumulates or moves while the FIFO is stalled, so full_state has no work here.
  assign unused_full_state = full_state;

  assign header_ok = detect_add && pkt_valid && (data_in[1:0] != 2'b11);

  always_comb begin
    header_reg_d = header_reg_q;
    if (header_ok) header_reg_d = data_in;
  end

  always_comb begin
    dout_d     = dout_q;
    hold_reg_d = hold_reg_q;
    if (lfd_state)                   dout_d     = header_reg_q;
    else if (ld_state && !fifo_full) dout_d     = data_in;
    else if (ld_state && fifo_full)  hold_reg_d = data_in;
    else if (laf_state)              dout_d     = hold_reg_q;
  end

  // The parity byte itself is captured separately and never folded into int_parity.
  always_comb begin
    int_parity_d = int_parity_q;
    pkt_parity_d = pkt_parity_q;
    if (header_ok)                   int_parity_d = 8'h00;
    else if (lfd_state)              int_parity_d = int_parity_q ^ header_reg_q;
    else if (ld_state && pkt_valid)  int_parity_d = int_parity_q ^ data_in;
    if (ld_state && !pkt_valid && !low_pkt_valid_q) pkt_parity_d = data_in;
  end

  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    if (rst_int_reg || detect_add)   low_pkt_valid_d = 1'b0;
    else if (ld_state && !pkt_valid) low_pkt_valid_d = 1'b1;
  end

  always_comb begin
    parity_done_d = parity_done_q;
    if (detect_add)
      parity_done_d = 1'b0;
    else if (ld_state && !pkt_valid && !fifo_full)
      parity_done_d = 1'b1;
    else if (laf_state && low_pkt_valid_q && !parity_done_q)
      parity_done_d = 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (detect_add)         err_d = 1'b0;
    else if (parity_done_q) err_d = (int_parity_q != pkt_parity_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q          <= 8'h00;
      header_reg_q    <= 8'h00;
      hold_reg_q      <= 8'h00;
      int_parity_q    <= 8'h00;
      pkt_parity_q    <= 8'h00;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_reg_q    <= header_reg_d;
      hold_reg_q      <= hold_reg_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign dout             = dout_q;
  assign parity_done      = parity_done_q;
  assign low_packet_valid = low_pkt_valid_q;
  assign err              = err_q;

endmodule

// File: tb/tb_r_register.sv
// Directed bench for r_register: per-cycle vector table covering good/bad parity,
// FIFO stall, parity byte during stall and invalid address, plus async reset sequences.
module tb_r_register;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_packet_valid, err;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_DA = 3'd1, S_LFD = 3'd2, S_LD = 3'd3,
                         S_FULL = 3'd4, S_LAF = 3'd5, S_RIR = 3'd6;

  typedef struct {
    logic [2:0] st;
    logic       pv;
    logic [7:0] din;
    logic       ff;
    logic [7:0] e_dout;
    logic       e_pd;
    logic       e_lpv;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  r_register dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] st, input logic pv, input logic [7:0] din,
                              input logic ff, input logic [7:0] ed, input logic epd,
                              input logic elpv, input logic eerr);
    vec_t r;
    r.st = st; r.pv = pv; r.din = din; r.ff = ff;
    r.e_dout = ed; r.e_pd = epd; r.e_lpv = elpv; r.e_err = eerr;
    return r;
  endfunction

  task automatic drive(input logic [2:0] st, input logic pv, input logic [7:0] din, input logic ff);
    pkt_valid   = pv;
    data_in     = din;
    fifo_full   = ff;
    detect_add  = (st == S_DA);
    lfd_state   = (st == S_LFD);
    ld_state    = (st == S_LD);
    full_state  = (st == S_FULL);
    laf_state   = (st == S_LAF);
    rst_int_reg = (st == S_RIR);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %02h expected %02h", name, row, act, exp);
  endtask

  task automatic chk_all(input string tag, input int row, input logic [7:0] ed,
                         input logic epd, input logic elpv, input logic eerr);
    chk({tag, ".dout"}, row, dout, ed);
    chk({tag, ".parity_done"}, row, {7'b0, parity_done}, {7'b0, epd});
    chk({tag, ".low_packet_valid"}, row, {7'b0, low_packet_valid}, {7'b0, elpv});
    chk({tag, ".err"}, row, {7'b0, err}, {7'b0, eerr});
  endtask

  initial begin
    resetn = 1'b0;
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
    tick; tick;
    chk_all("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;

    // Good packet: header 0D, payload 11 22 33, parity 0D
    vecs.push_back(mk(S_DA,   1, 8'h0D, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(S_LFD,  1, 8'h11, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h11, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h22, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h33, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(S_LD,   0, 8'h0D, 0, 8'h0D, 1, 1, 0));
    vecs.push_back(mk(S_IDLE, 0, 8'h00, 0, 8'h0D, 1, 1, 0));
    vecs.push_back(mk(S_RIR,  0, 8'h00, 0, 8'h0D, 1, 0, 0));
    // Bad parity 0E
    vecs.push_back(mk(S_DA,   1, 8'h0D, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LFD,  1, 8'h11, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h11, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h22, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h33, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(S_LD,   0, 8'h0E, 0, 8'h0E, 1, 1, 0));
    vecs.push_back(mk(S_IDLE, 0, 8'h00, 0, 8'h0E, 1, 1, 1));
    vecs.push_back(mk(S_RIR,  0, 8'h00, 0, 8'h0E, 1, 0, 1));
    // FIFO full while 22 is presented
    vecs.push_back(mk(S_DA,   1, 8'h0D, 0, 8'h0E, 0, 0, 0));
    vecs.push_back(mk(S_LFD,  1, 8'h11, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h11, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h22, 1, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_FULL, 1, 8'h33, 1, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_FULL, 1, 8'h33, 1, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_FULL, 1, 8'h33, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_LAF,  1, 8'h33, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h33, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(S_LD,   0, 8'h0D, 0, 8'h0D, 1, 1, 0));
    vecs.push_back(mk(S_IDLE, 0, 8'h00, 0, 8'h0D, 1, 1, 0));
    // Parity byte arrives with the FIFO full
    vecs.push_back(mk(S_DA,   1, 8'h0D, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LFD,  1, 8'h11, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h11, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h22, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(S_LD,   1, 8'h33, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(S_LD,   0, 8'h0D, 1, 8'h33, 0, 1, 0));
    vecs.push_back(mk(S_FULL, 0, 8'h00, 1, 8'h33, 0, 1, 0));
    vecs.push_back(mk(S_FULL, 0, 8'h00, 0, 8'h33, 0, 1, 0));
    vecs.push_back(mk(S_LAF,  0, 8'h00, 0, 8'h0D, 1, 1, 0));
    vecs.push_back(mk(S_RIR,  0, 8'h00, 0, 8'h0D, 1, 0, 0));
    vecs.push_back(mk(S_IDLE, 0, 8'h00, 0, 8'h0D, 1, 0, 0));
    // Invalid address 0F: header stays 0D, int_parity keeps 0D so 0D^0D=00 matches parity 00
    vecs.push_back(mk(S_DA,   1, 8'h0F, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LFD,  1, 8'h00, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(S_LD,   0, 8'h00, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(S_IDLE, 0, 8'h00, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(S_DA,   0, 8'h00, 0, 8'h00, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].pv, vecs[i].din, vecs[i].ff);
      tick;
      chk_all("vec", i + 1, vecs[i].e_dout, vecs[i].e_pd, vecs[i].e_lpv, vecs[i].e_err);
    end

    // Async reset with every status bit set: short packet with wrong parity
    drive(S_DA, 1, 8'h05, 0);  tick;   // header len 1 addr 1
    drive(S_LFD, 1, 8'h44, 0); tick;
    drive(S_LD, 1, 8'h44, 0);  tick;
    drive(S_LD, 0, 8'h99, 0);  tick;   // expected parity would be 05^44=41
    drive(S_IDLE, 0, 8'h00, 0); tick;
    chk_all("pre_reset", 100, 8'h99, 1'b1, 1'b1, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk_all("async_reset", 101, 8'h00, 1'b0, 1'b0, 1'b0);
    tick;
    resetn = 1'b1;

    // Async reset mid-payload, then check header_reg was wiped
    drive(S_DA, 1, 8'h0D, 0);  tick;
    drive(S_LFD, 1, 8'h11, 0); tick;
    drive(S_LD, 1, 8'h11, 0);  tick;
    chk("midpay.dout", 102, dout, 8'h11);
    drive(S_LD, 1, 8'h22, 0);
    #2 resetn = 1'b0;
    #1;
    chk("midpay_reset.dout", 103, dout, 8'h00);
    tick;
    resetn = 1'b1;
    drive(S_LFD, 1, 8'h00, 0); tick;
    chk("post_reset_header.dout", 104, dout, 8'h00);
    drive(S_LD, 0, 8'h00, 0); tick;
    drive(S_IDLE, 0, 8'h00, 0); tick;
    chk_all("post_reset_parity", 105, 8'h00, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
